jtag_master: RTL and testbench

- Host-side JTAG scan engine: drives tms/tdi into a JTAG TAP controller and captures tdo from it.
- Accepts one command at a time: TAP reset, IR scan, DR scan, or idle cycles.
- Tracks the TAP state internally and always returns it to Run-Test/Idle.
- Used as the stimulus/control front-end for the TAP in system bring-up and in test benches.

---
 rtl/jtag_pkg.sv | 51 +++++
 rtl/jtag_tap_shadow.sv | 42 ++++
 rtl/jtag_master.sv | 204 ++++++++++++++++++++
 tb/tb_jtag_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, engine opcodes, FSM states
// and the fixed TMS patterns the engine drives (bit 0 is driven first).
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_t;

  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HDR,
    ST_SHIFT,
    ST_TRL,
    ST_RUN
  } eng_state_t;

  // Five ones force Test-Logic-Reset from anywhere, the trailing zero lands in Run-Test/Idle
  localparam logic [5:0] RST_TMS     = 6'b011111;
  localparam logic [5:0] RST_LAST    = 6'd5;
  // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [5:0] HDR_IR_TMS  = 6'b000011;
  localparam logic [5:0] HDR_IR_LAST = 6'd3;
  // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [5:0] HDR_DR_TMS  = 6'b000001;
  localparam logic [5:0] HDR_DR_LAST = 6'd2;
  // Exit1 -> Update -> Run-Test/Idle
  localparam logic [5:0] TRL_TMS     = 6'b000001;
  localparam logic [5:0] TRL_LAST    = 6'd1;

endpackage

// File: rtl/jtag_tap_shadow.sv
// Shadow copy of the IEEE 1149.1 TAP state machine, advanced by the TMS
// value the TAP sees on each rising tck.
module jtag_tap_shadow
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
    tap_state_t n;
    case (s)
      TAP_RESET:      n = m ? TAP_RESET      : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   n = m ? TAP_SELECT_DR  : TAP_RUN_IDLE;
      TAP_SELECT_DR:  n = m ? TAP_SELECT_IR  : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = m ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = m ? TAP_EXIT1_DR   : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = m ? TAP_UPDATE_DR  : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = m ? TAP_EXIT2_DR   : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = m ? TAP_UPDATE_DR  : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = m ? TAP_SELECT_DR  : TAP_RUN_IDLE;
      TAP_SELECT_IR:  n = m ? TAP_RESET      : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = m ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = m ? TAP_EXIT1_IR   : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = m ? TAP_UPDATE_IR  : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = m ? TAP_EXIT2_IR   : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = m ? TAP_UPDATE_IR  : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = m ? TAP_SELECT_DR  : TAP_RUN_IDLE;
      default:        n = TAP_RESET;
    endcase
    return n;
  endfunction

  // Follow the TAP one transition per tck using the tms it consumes
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TAP_RESET;
    else       state <= tap_next(state, tms);
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG scan engine. Runs one command at a time (TAP reset, IR scan,
// DR scan, idle cycles), drives registered tms/tdi, captures tdo and always
// leaves the TAP in Run-Test/Idle.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int IR_LEN = 4,
  parameter int DR_MAX = 32
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [5:0]        cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [5:0]        IR_LEN6 = 6'(IR_LEN);
  localparam logic [5:0]        DR_MAX6 = 6'(DR_MAX);
  localparam logic [DR_MAX-1:0] DR_ONE  = {{(DR_MAX-1){1'b0}}, 1'b1};

  eng_state_t        state, state_d;
  logic [5:0]        cnt, cnt_d;
  logic [5:0]        len_q, len_d;
  logic [1:0]        op_q, op_d;
  logic [DR_MAX-1:0] data_q, data_d;
  logic [DR_MAX-1:0] cap_q;
  logic              active_q, active_d;
  logic              accept;
  logic              complete;
  logic              tms_d, tdi_d;
  logic [5:0]        hdr_last;
  tap_state_t        tap_state;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign hdr_last  = (op_q == OP_IR) ? HDR_IR_LAST : HDR_DR_LAST;
  assign complete  = (state != ST_IDLE) && (state_d == ST_IDLE) && active_q;

  // Sequence the command phases, then derive the pair for the upcoming cycle
  // from the next state so tms/tdi stay aligned with the state they belong to
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    len_d    = len_q;
    op_d     = op_q;
    data_d   = data_q;
    active_d = active_q;
    accept   = 1'b0;
    tms_d    = 1'b0;
    tdi_d    = 1'b0;

    case (state)
      ST_INIT: begin
        if (cnt == RST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      ST_IDLE: begin
        active_d = 1'b0;
        if (cmd_valid) begin
          accept   = 1'b1;
          active_d = 1'b1;
          op_d     = cmd_op;
          data_d   = cmd_data;
          cnt_d    = 6'd0;
          case (cmd_op)
            OP_RST: begin
              state_d = ST_INIT;
              len_d   = 6'd0;
            end
            OP_IR: begin
              state_d = ST_HDR;
              len_d   = IR_LEN6;
            end
            OP_DR: begin
              state_d = ST_HDR;
              if (cmd_len == 6'd0)         len_d = 6'd1;
              else if (cmd_len > DR_MAX6)  len_d = DR_MAX6;
              else                         len_d = cmd_len;
            end
            default: begin
              state_d = ST_RUN;
              len_d   = (cmd_len == 6'd0) ? 6'd1 : cmd_len;
            end
          endcase
        end
      end
      ST_HDR: begin
        if (cnt == hdr_last) begin
          state_d = ST_SHIFT;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt == len_q - 6'd1) begin
          state_d = ST_TRL;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      ST_TRL: begin
        if (cnt == TRL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      ST_RUN: begin
        if (cnt == len_q - 6'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt + 6'd1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 6'd0;
      end
    endcase

    case (state_d)
      ST_INIT:  tms_d = |(RST_TMS & (6'd1 << cnt_d));
      ST_HDR:   tms_d = |(((op_d == OP_IR) ? HDR_IR_TMS : HDR_DR_TMS) & (6'd1 << cnt_d));
      ST_SHIFT: begin
        tms_d = (cnt_d == len_d - 6'd1);
        tdi_d = |(data_d & (DR_ONE << cnt_d));
      end
      ST_TRL:   tms_d = |(TRL_TMS & (6'd1 << cnt_d));
      default: begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
      end
    endcase
  end

  // Engine state, latched command and the registered tms/tdi pair
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state    <= ST_INIT;
      cnt      <= 6'd0;
      len_q    <= 6'd0;
      op_q     <= OP_RST;
      data_q   <= '0;
      active_q <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      len_q    <= len_d;
      op_q     <= op_d;
      data_q   <= data_d;
      active_q <= active_d;
      tms      <= tms_d;
      tdi      <= tdi_d;
    end
  end

  // Sample tdo on the edge where the TAP shifts bit cnt, storing it at bit cnt
  always_ff @(posedge tck or negedge trst) begin
    if (!trst)                  cap_q <= '0;
    else if (accept)            cap_q <= '0;
    else if (state == ST_SHIFT) cap_q <= cap_q | ({DR_MAX{tdo}} & (DR_ONE << cnt));
  end

  // Publish the result as the engine returns to IDLE after a real command
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= complete;
      if (complete) rsp_data <= ((op_q == OP_IR) || (op_q == OP_DR)) ? cap_q : '0;
    end
  end

  jtag_tap_shadow u_shadow (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (tap_state)
  );

  // The shadow TAP has to be parked in Run-Test/Idle whenever the engine is idle
  a_idle_in_rti: assert property (@(posedge tck) disable iff (!trst)
    (state == ST_IDLE) |-> (tap_state == TAP_RUN_IDLE));

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master with a behavioural TAP (IR and DR shift
// registers, fixed capture values) connected to tms/tdi/tdo.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int IR_LEN = 4;
  localparam int DR_MAX = 32;
  localparam int CYCLE_LIMIT = 100;
  localparam logic [3:0] IR_CAP = 4'b0001;

  logic              tck = 1'b0;
  logic              trst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'd0;
  logic [5:0]        cmd_len = 6'd0;
  logic [DR_MAX-1:0] cmd_data = '0;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DR_MAX-1:0] rsp_data;
  logic              busy;
  logic              tms;
  logic              tdi;
  logic              tdo;

  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic [63:0] tms_log;
  logic [63:0] tdi_log;
  logic        pulse_seen;

  tap_state_t        tap_state;
  logic [3:0]        ir_sr;
  logic [3:0]        ir_reg;
  logic [DR_MAX-1:0] dr_sr;
  logic [DR_MAX-1:0] dr_cap_val = '0;

  jtag_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX)) dut (
    .tck       (tck),
    .trst      (trst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 tck = ~tck;

  function automatic tap_state_t tbTapNext(input tap_state_t s, input logic m);
    case (s)
      TAP_RESET:      return m ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   return m ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  return m ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: return m ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   return m ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   return m ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   return m ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   return m ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  return m ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  return m ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: return m ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   return m ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   return m ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   return m ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   return m ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      default:        return m ? TAP_SELECT_DR : TAP_RUN_IDLE;
    endcase
  endfunction

  // Behavioural TAP: capture, shift and update of IR and DR
  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_state <= TAP_RESET;
      ir_sr     <= '0;
      ir_reg    <= '0;
      dr_sr     <= '0;
    end else begin
      case (tap_state)
        TAP_CAPTURE_DR: dr_sr  <= dr_cap_val;
        TAP_SHIFT_DR:   dr_sr  <= {tdi, dr_sr[DR_MAX-1:1]};
        TAP_CAPTURE_IR: ir_sr  <= IR_CAP;
        TAP_SHIFT_IR:   ir_sr  <= {tdi, ir_sr[IR_LEN-1:1]};
        TAP_UPDATE_IR:  ir_reg <= ir_sr;
        default: ;
      endcase
      tap_state <= tbTapNext(tap_state, tms);
    end
  end

  assign tdo = (tap_state == TAP_SHIFT_DR) ? dr_sr[0] :
               (tap_state == TAP_SHIFT_IR) ? ir_sr[0] : 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Offer a command at the current negedge (engine idle), then log tms/tdi
  // per cycle until rsp_valid is seen; returns at the rsp_valid negedge
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] len, input logic [DR_MAX-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge tck);
    cmd_valid = 1'b0;
    cmd_len   = ~len;
    cmd_data  = ~data;
    cyc       = 0;
    tms_log   = '0;
    tdi_log   = '0;
    while (!rsp_valid && cyc < CYCLE_LIMIT) begin
      if (cyc < 64) begin
        tms_log[cyc] = tms;
        tdi_log[cyc] = tdi;
      end
      cyc++;
      @(negedge tck);
    end
    checkOutput("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    $display("[TB] start");

    // Held in reset
    repeat (2) @(negedge tck);
    checkOutput("rst_tms",       64'(tms),       64'd1);
    checkOutput("rst_tdi",       64'(tdi),       64'd0);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_data",  64'(rsp_data),  64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd1);

    // Release: INIT sequence 1,1,1,1,1,0 then idle
    trst = 1'b1;
    cyc = 0;
    tms_log = '0;
    pulse_seen = 1'b0;
    while (!cmd_ready && cyc < 20) begin
      tms_log[cyc] = tms;
      pulse_seen = pulse_seen | rsp_valid;
      cyc++;
      @(negedge tck);
    end
    checkOutput("init_tms",      tms_log,          64'h1F);
    checkOutput("init_cycles",   64'(cyc),         64'd6);
    checkOutput("init_busy",     64'(busy),        64'd0);
    checkOutput("init_no_rsp",   64'(pulse_seen | rsp_valid), 64'd0);
    checkOutput("init_tap_rti",  64'(tap_state),   64'(TAP_RUN_IDLE));

    // DR scan, 8 bits of 0xA5, TAP captures 0x3C
    dr_cap_val = 32'h3C;
    applyStimulus(OP_DR, 6'd8, 32'hA5);
    checkOutput("dr8_tms",       tms_log,          64'hC01);
    checkOutput("dr8_cycles",    64'(cyc),         64'd13);
    checkOutput("dr8_tdi",       64'(tdi_log[10:3]), 64'hA5);
    checkOutput("dr8_rsp",       64'(rsp_data),    64'h3C);
    checkOutput("dr8_tap_rti",   64'(tap_state),   64'(TAP_RUN_IDLE));
    @(negedge tck);
    checkOutput("dr8_pulse_end", 64'(rsp_valid),   64'd0);
    checkOutput("dr8_ready",     64'(cmd_ready),   64'd1);

    // IR scan of 4'b1010, TAP captures 4'b0001
    applyStimulus(OP_IR, 6'd0, 32'hA);
    checkOutput("ir_tms",        tms_log,          64'h183);
    checkOutput("ir_cycles",     64'(cyc),         64'd10);
    checkOutput("ir_tdi",        64'(tdi_log[7:4]), 64'hA);
    checkOutput("ir_rsp",        64'(rsp_data),    64'h1);
    checkOutput("ir_tap_ir",     64'(ir_reg),      64'hA);
    @(negedge tck);
    checkOutput("ir_pulse_end",  64'(rsp_valid),   64'd0);

    // Idle x3 followed by a DR scan offered on the rsp_valid cycle
    applyStimulus(OP_IDLE, 6'd3, 32'h0);
    checkOutput("idle3_cycles",  64'(cyc),         64'd3);
    checkOutput("idle3_tms",     tms_log,          64'h0);
    checkOutput("idle3_rsp",     64'(rsp_data),    64'h0);
    checkOutput("idle3_ready",   64'(cmd_ready),   64'd1);
    dr_cap_val = 32'hBEEF;
    applyStimulus(OP_DR, 6'd16, 32'h1234);
    checkOutput("b2b_tms",       tms_log,          64'hC0001);
    checkOutput("b2b_cycles",    64'(cyc),         64'd21);
    checkOutput("b2b_tdi",       64'(tdi_log[18:3]), 64'h1234);
    checkOutput("b2b_rsp",       64'(rsp_data),    64'hBEEF);
    @(negedge tck);

    // TAP reset command
    applyStimulus(OP_RST, 6'd9, 32'hFFFF);
    checkOutput("rst_cmd_tms",   tms_log,          64'h1F);
    checkOutput("rst_cmd_cycles", 64'(cyc),        64'd6);
    checkOutput("rst_cmd_rsp",   64'(rsp_data),    64'h0);
    checkOutput("rst_cmd_rti",   64'(tap_state),   64'(TAP_RUN_IDLE));
    @(negedge tck);

    // DR length 0 becomes a 1-bit scan; upper response bits stay zero
    dr_cap_val = 32'hFFFF_FFFF;
    applyStimulus(OP_DR, 6'd0, 32'h1);
    checkOutput("dr0_tms",       tms_log,          64'h19);
    checkOutput("dr0_cycles",    64'(cyc),         64'd6);
    checkOutput("dr0_tdi",       64'(tdi_log[3]),  64'd1);
    checkOutput("dr0_rsp",       64'(rsp_data),    64'h1);
    @(negedge tck);

    // DR length 40 clamps to a 32-bit scan
    dr_cap_val = 32'h1234_5678;
    applyStimulus(OP_DR, 6'd40, 32'hDEAD_BEEF);
    checkOutput("dr40_tms",      tms_log,          64'h0000_000C_0000_0001);
    checkOutput("dr40_cycles",   64'(cyc),         64'd37);
    checkOutput("dr40_tdi",      64'(tdi_log[34:3]), 64'hDEAD_BEEF);
    checkOutput("dr40_rsp",      64'(rsp_data),    64'h1234_5678);
    @(negedge tck);

    // Reset during shift bit 3 of an 8-bit DR scan
    dr_cap_val = 32'h99;
    cmd_valid = 1'b1;
    cmd_op    = OP_DR;
    cmd_len   = 6'd8;
    cmd_data  = 32'h55;
    @(negedge tck);
    cmd_valid = 1'b0;
    repeat (6) @(negedge tck);
    checkOutput("mid_busy",      64'(busy),        64'd1);
    trst = 1'b0;
    #1;
    checkOutput("mid_tms",       64'(tms),         64'd1);
    checkOutput("mid_tdi",       64'(tdi),         64'd0);
    checkOutput("mid_ready",     64'(cmd_ready),   64'd0);
    checkOutput("mid_rsp_data",  64'(rsp_data),    64'h0);
    pulse_seen = rsp_valid;
    repeat (3) begin
      @(negedge tck);
      pulse_seen = pulse_seen | rsp_valid;
    end
    trst = 1'b1;
    cyc = 0;
    tms_log = '0;
    while (!cmd_ready && cyc < 20) begin
      tms_log[cyc] = tms;
      pulse_seen = pulse_seen | rsp_valid;
      cyc++;
      @(negedge tck);
    end
    checkOutput("mid_no_rsp",    64'(pulse_seen | rsp_valid), 64'd0);
    checkOutput("reinit_tms",    tms_log,          64'h1F);
    checkOutput("reinit_cycles", 64'(cyc),         64'd6);

    dr_cap_val = 32'hC3;
    applyStimulus(OP_DR, 6'd8, 32'h0F);
    checkOutput("post_tms",      tms_log,          64'hC01);
    checkOutput("post_rsp",      64'(rsp_data),    64'hC3);
    checkOutput("post_tap_rti",  64'(tap_state),   64'(TAP_RUN_IDLE));
    @(negedge tck);

    // Idle length 0 runs a single cycle
    applyStimulus(OP_IDLE, 6'd0, 32'h0);
    checkOutput("idle0_cycles",  64'(cyc),         64'd1);
    checkOutput("idle0_rsp",     64'(rsp_data),    64'h0);
    @(negedge tck);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
